axil_seq_checker: RTL and testbench
===================================

AXIL_SEQ_CHECKER -- requirements
Module: axil_seq_checker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32 (32 or 64): AXI4-Lite data width.
REQ-003 SHALL have parameter NUM_WORDS, default 4 (1..256): number of words written and read back.
REQ-004 SHALL have parameter BASE_ADDR, default 0: address of word 0.
REQ-005 SHALL have parameter SEED, default 1: pattern for word 0.
REQ-006 SHALL have parameter MODE, default 0: 0 = incrementing pattern, 1 = 32-bit Galois LFSR pattern (taps 0x80200003), replicated to DATA_WIDTH.
REQ-007 SHALL have parameter TIMEOUT, default 1024: maximum cycles per handshake.
REQ-008 SHALL have port ACLK, input, 1 bit: the single clock.
REQ-009 SHALL have port ARESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port start, input, 1 bit: single-cycle pulse that launches a run.
REQ-011 SHALL have ports busy, done, pass, timeout, all outputs, 1 bit each: run status.
REQ-012 SHALL have port err_count, output, $clog2(NUM_WORDS+1) bits: number of mismatches plus non-OKAY responses, saturating.
REQ-013 SHALL have port first_err_idx, output, 8 bits: index of the first failing word.
REQ-014 SHALL have the AXI4-Lite master write channels: M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY.
REQ-015 SHALL have the AXI4-Lite master read channels: M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY.

Function
REQ-016 SHALL use FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-017 IDLE/DONE + start=1 SHALL go to WR_REQ next cycle, setting index=0, clearing err_count, pass, timeout and first_err_idx, and setting busy=1, done=0.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 Address of word i SHALL be BASE_ADDR + i*(DATA_WIDTH/8), truncated to ADDR_WIDTH; AWPROT=ARPROT=0; WSTRB all ones.
REQ-020 Pattern in MODE 0: P(0)=SEED, P(i)=P(i-1)+1 modulo 2^DATA_WIDTH.
REQ-021 Pattern in MODE 1: P(0)=SEED, with a SEED of 0 forced to 1; P(i)=LFSR step of P(i-1).
REQ-022 The read phase SHALL regenerate the pattern from SEED and SHALL NOT store it.
REQ-023 WR_REQ SHALL assert AWVALID and WVALID in the same cycle; each SHALL drop the cycle after its own READY handshake.
REQ-024 WR_REQ SHALL exit to WR_RESP only when both handshakes are done, in either order or simultaneously.
REQ-025 Once asserted, AWVALID and WVALID SHALL NOT drop before their handshake, and their payload SHALL stay stable.
REQ-026 In WR_RESP, BREADY SHALL be 1; on BVALID a BRESP other than OKAY SHALL count as an error.
REQ-027 After the B handshake: index<NUM_WORDS-1 -> index+1, back to WR_REQ; otherwise index=0, pattern reseeded, go to RD_REQ.
REQ-028 RD_REQ SHALL assert ARVALID until ARREADY, then go to RD_RESP.
REQ-029 In RD_RESP, RREADY SHALL be 1; on RVALID, RDATA!=P(index) or RRESP!=OKAY SHALL count as one error.
REQ-030 After the R handshake, the FSM SHALL advance as in REQ-027, going to DONE after the last word.
REQ-031 On the first error of a run, first_err_idx SHALL capture index; err_count SHALL saturate at all ones.
REQ-032 Each handshake state SHALL count cycles; on reaching TIMEOUT without handshake, timeout=1 and all VALIDs drop the next cycle.
REQ-033 After a timeout the FSM SHALL go to DONE with pass=0.
REQ-034 On entering DONE: busy=0, done=1, pass=(err_count==0 && timeout==0); these hold until the next start.
REQ-035 Minimum cost per word SHALL be 2 cycles per write and 2 cycles per read with zero-latency slave ready/valid.

Reset
REQ-036 ARESETN=0 SHALL asynchronously force IDLE and set all VALID/READY outputs, busy, done, pass, timeout, err_count and first_err_idx to 0.
REQ-037 Address/data outputs SHALL reset to 0.
REQ-038 Reset mid-transaction SHALL abort immediately with no further handshakes.
REQ-039 Operation SHALL resume on the first ACLK edge after ARESETN deasserts.

Verification
REQ-040 Defaults, memory-backed slave, start -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match; done=1, pass=1, err_count=0.
REQ-041 Slave corrupts read of word 2 (0x3 -> 0x7) -> pass=0, err_count=1, first_err_idx=2.
REQ-042 Slave returns AWREADY 3 cycles before WREADY, and also the reverse -> exactly one write per word, pass=1.
REQ-043 MODE=1, SEED=0, NUM_WORDS=8, DATA_WIDTH=64 -> word 0 = 0x0000000100000001, the LFSR sequence reads back, pass=1.
REQ-044 ARREADY held 0, TIMEOUT=16 -> ARVALID drops 17 cycles after assertion; timeout=1, pass=0, done=1.
REQ-045 ARESETN pulled low during the 3rd write with AWVALID high -> AWVALID=WVALID=0 immediately, busy=0; a later start completes a full run with pass=1.

Source files
------------

// File: rtl/axil_seq_checker.sv
// AXI4-Lite sequence checker: writes a generated pattern to NUM_WORDS words,
// reads them back, regenerates the pattern on the fly and reports mismatches.
module axil_seq_checker #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WORDS  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [63:0]           SEED       = 64'd1,
    parameter int                    MODE       = 0,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [$clog2(NUM_WORDS+1)-1:0]   err_count,
    output logic [7:0]                       first_err_idx,
    output logic [ADDR_WIDTH-1:0]            M_AXI_AWADDR,
    output logic [2:0]                       M_AXI_AWPROT,
    output logic                             M_AXI_AWVALID,
    input  logic                             M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]            M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
    output logic                             M_AXI_WVALID,
    input  logic                             M_AXI_WREADY,
    input  logic [1:0]                       M_AXI_BRESP,
    input  logic                             M_AXI_BVALID,
    output logic                             M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]            M_AXI_ARADDR,
    output logic [2:0]                       M_AXI_ARPROT,
    output logic                             M_AXI_ARVALID,
    input  logic                             M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]            M_AXI_RDATA,
    input  logic [1:0]                       M_AXI_RRESP,
    input  logic                             M_AXI_RVALID,
    output logic                             M_AXI_RREADY
);
    localparam int                    EW     = $clog2(NUM_WORDS + 1);
    localparam int                    TW     = $clog2(TIMEOUT + 1);
    localparam logic [7:0]            LAST   = 8'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [TW-1:0]         TLOAD  = TW'(TIMEOUT);
    localparam logic [31:0]           TAPS   = 32'h8020_0003;
    localparam logic [31:0]           SEED32 = (SEED[31:0] == 32'd0) ? 32'd1 : SEED[31:0];
    localparam logic [DATA_WIDTH-1:0] PAT0   = (MODE == 1) ? {(DATA_WIDTH/32){SEED32}}
                                                           : DATA_WIDTH'(SEED);

    // IDLE | DONE: waiting for start; WR_REQ/WR_RESP: AW+W issue, B wait; RD_REQ/RD_RESP: AR issue, R check
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   pat_q, pat_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [EW-1:0]           err_q, err_d;
    logic [7:0]              first_q, first_d;
    logic                    pass_q, pass_d, timeout_q, timeout_d;
    logic                    err_hit, advance, tmr_zero;

    function automatic logic [DATA_WIDTH-1:0] pat_next(input logic [DATA_WIDTH-1:0] p);
        logic [31:0] s;
        if (MODE == 1) begin
            s = {1'b0, p[31:1]} ^ (p[0] ? TAPS : 32'd0);
            return {(DATA_WIDTH/32){s}};
        end
        return p + DATA_WIDTH'(1);
    endfunction

    assign tmr_zero = (tmr_q == '0);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            pat_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            tmr_q     <= '0;
            err_q     <= '0;
            first_q   <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        tmr_d     = tmr_q;
        err_d     = err_q;
        first_d   = first_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_hit   = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = WR_REQ;
                    idx_d     = '0;
                    addr_d    = BASE_ADDR;
                    pat_d     = PAT0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    tmr_d     = TLOAD;
                    err_d     = '0;
                    first_d   = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
                w_done_d  = w_done_q | (M_AXI_WVALID & M_AXI_WREADY);
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                    tmr_d   = TLOAD;
                end else if (tmr_zero) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    err_hit = (M_AXI_BRESP != 2'b00);
                    advance = 1'b1;
                end else if (tmr_zero) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    state_d = RD_RESP;
                    tmr_d   = TLOAD;
                end else if (tmr_zero) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            RD_RESP: begin
                if (M_AXI_RVALID) begin
                    err_hit = (M_AXI_RDATA != pat_q) || (M_AXI_RRESP != 2'b00);
                    advance = 1'b1;
                end else if (tmr_zero) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The read pass regenerates the pattern from the seed rather than storing it.
        if (advance) begin
            tmr_d     = TLOAD;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (idx_q == LAST) begin
                idx_d   = '0;
                addr_d  = BASE_ADDR;
                pat_d   = PAT0;
                state_d = (state_q == WR_RESP) ? RD_REQ : DONE;
            end else begin
                idx_d   = idx_q + 8'd1;
                addr_d  = addr_q + STEP;
                pat_d   = pat_next(pat_q);
                state_d = (state_q == WR_RESP) ? WR_REQ : RD_REQ;
            end
        end

        if (err_hit) begin
            if (err_q != '1) err_d = err_q + EW'(1);
            if (err_q == '0) first_d = idx_q;
        end

        if (state_d == DONE && state_q != DONE) pass_d = (err_d == '0) && !timeout_d;
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = pat_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = (state_q == WR_REQ) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARVALID = (state_q == RD_REQ);
    assign M_AXI_RREADY  = (state_q == RD_RESP);

    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
endmodule

// File: tb/tb_axil_seq_checker.sv
// Scoreboard bench: two checker instances (32-bit incrementing, 64-bit LFSR)
// share one memory-backed AXI4-Lite slave selected by sel.
module tb_axil_seq_checker;
    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic rst0_n, rst1_n, slv_rst_n, start0, start1, sel;
    assign slv_rst_n = rst0_n & rst1_n;

    int n_pass = 0;
    int n_total = 0;

    // dut0 signals
    logic d0_busy, d0_done, d0_pass, d0_to;
    logic [2:0] d0_err;
    logic [7:0] d0_fi;
    logic [31:0] d0_awaddr, d0_wdata, d0_araddr;
    logic [2:0] d0_awprot, d0_arprot;
    logic [3:0] d0_wstrb;
    logic d0_awvalid, d0_wvalid, d0_bready, d0_arvalid, d0_rready;
    // dut1 signals
    logic d1_busy, d1_done, d1_pass, d1_to;
    logic [3:0] d1_err;
    logic [7:0] d1_fi;
    logic [31:0] d1_awaddr, d1_araddr;
    logic [63:0] d1_wdata;
    logic [2:0] d1_awprot, d1_arprot;
    logic [7:0] d1_wstrb;
    logic d1_awvalid, d1_wvalid, d1_bready, d1_arvalid, d1_rready;
    // slave
    logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [63:0] s_rdata;
    logic [1:0] resp_ok = 2'b00;
    int aw_dly, w_dly, aw_cnt, w_cnt;
    logic ar_block, corrupt;
    logic aw_got, w_got;
    logic [31:0] aw_a;
    logic [63:0] w_d;
    logic [63:0] mem [16];

    axil_seq_checker #(.TIMEOUT(16)) dut0 (
        .ACLK(ACLK), .ARESETN(rst0_n), .start(start0),
        .busy(d0_busy), .done(d0_done), .pass(d0_pass), .timeout(d0_to),
        .err_count(d0_err), .first_err_idx(d0_fi),
        .M_AXI_AWADDR(d0_awaddr), .M_AXI_AWPROT(d0_awprot), .M_AXI_AWVALID(d0_awvalid),
        .M_AXI_AWREADY(s_awready),
        .M_AXI_WDATA(d0_wdata), .M_AXI_WSTRB(d0_wstrb), .M_AXI_WVALID(d0_wvalid),
        .M_AXI_WREADY(s_wready),
        .M_AXI_BRESP(resp_ok), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(d0_bready),
        .M_AXI_ARADDR(d0_araddr), .M_AXI_ARPROT(d0_arprot), .M_AXI_ARVALID(d0_arvalid),
        .M_AXI_ARREADY(s_arready),
        .M_AXI_RDATA(s_rdata[31:0]), .M_AXI_RRESP(resp_ok), .M_AXI_RVALID(s_rvalid),
        .M_AXI_RREADY(d0_rready)
    );

    axil_seq_checker #(.DATA_WIDTH(64), .NUM_WORDS(8), .SEED(64'd0), .MODE(1), .TIMEOUT(16)) dut1 (
        .ACLK(ACLK), .ARESETN(rst1_n), .start(start1),
        .busy(d1_busy), .done(d1_done), .pass(d1_pass), .timeout(d1_to),
        .err_count(d1_err), .first_err_idx(d1_fi),
        .M_AXI_AWADDR(d1_awaddr), .M_AXI_AWPROT(d1_awprot), .M_AXI_AWVALID(d1_awvalid),
        .M_AXI_AWREADY(s_awready),
        .M_AXI_WDATA(d1_wdata), .M_AXI_WSTRB(d1_wstrb), .M_AXI_WVALID(d1_wvalid),
        .M_AXI_WREADY(s_wready),
        .M_AXI_BRESP(resp_ok), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(d1_bready),
        .M_AXI_ARADDR(d1_araddr), .M_AXI_ARPROT(d1_arprot), .M_AXI_ARVALID(d1_arvalid),
        .M_AXI_ARREADY(s_arready),
        .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(resp_ok), .M_AXI_RVALID(s_rvalid),
        .M_AXI_RREADY(d1_rready)
    );

    // view of whichever instance is currently selected
    logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_done, m_busy, m_pass, m_to;
    logic [31:0] m_awaddr, m_araddr;
    logic [2:0] m_awprot, m_arprot;
    logic [63:0] m_wdata;
    logic [7:0] m_wstrb, m_fi;
    logic [3:0] m_err;
    assign m_awvalid = sel ? d1_awvalid : d0_awvalid;
    assign m_wvalid  = sel ? d1_wvalid  : d0_wvalid;
    assign m_bready  = sel ? d1_bready  : d0_bready;
    assign m_arvalid = sel ? d1_arvalid : d0_arvalid;
    assign m_rready  = sel ? d1_rready  : d0_rready;
    assign m_done    = sel ? d1_done    : d0_done;
    assign m_busy    = sel ? d1_busy    : d0_busy;
    assign m_pass    = sel ? d1_pass    : d0_pass;
    assign m_to      = sel ? d1_to      : d0_to;
    assign m_awaddr  = sel ? d1_awaddr  : d0_awaddr;
    assign m_araddr  = sel ? d1_araddr  : d0_araddr;
    assign m_awprot  = sel ? d1_awprot  : d0_awprot;
    assign m_arprot  = sel ? d1_arprot  : d0_arprot;
    assign m_wdata   = sel ? d1_wdata   : {32'h0, d0_wdata};
    assign m_wstrb   = sel ? d1_wstrb   : {4'h0, d0_wstrb};
    assign m_fi      = sel ? d1_fi      : d0_fi;
    assign m_err     = sel ? d1_err     : {1'b0, d0_err};

    assign s_awready = m_awvalid && (aw_cnt >= aw_dly);
    assign s_wready  = m_wvalid && (w_cnt >= w_dly);
    assign s_arready = m_arvalid && !ar_block;

    function automatic int widx(input logic [31:0] a);
        return sel ? int'(a[6:3]) : int'(a[5:2]);
    endfunction

    always @(posedge ACLK or negedge slv_rst_n) begin
        if (!slv_rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_a <= '0; w_d <= '0; s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0;
        end else begin
            aw_cnt <= (m_awvalid && !s_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_wvalid && !s_wready) ? w_cnt + 1 : 0;
            if (m_awvalid && s_awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
            if (m_wvalid && s_wready) begin w_got <= 1'b1; w_d <= m_wdata; end
            if (s_bvalid && m_bready) s_bvalid <= 1'b0;
            if ((aw_got || (m_awvalid && s_awready)) && (w_got || (m_wvalid && s_wready))) begin
                mem[widx((m_awvalid && s_awready) ? m_awaddr : aw_a)] <=
                    (m_wvalid && s_wready) ? m_wdata : w_d;
                aw_got <= 1'b0;
                w_got <= 1'b0;
                s_bvalid <= 1'b1;
            end
            if (m_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                s_rdata <= mem[widx(m_araddr)] ^ ((corrupt && widx(m_araddr) == 2) ? 64'h4 : 64'h0);
            end else if (s_rvalid && m_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    typedef struct packed {logic p; logic [3:0] e; logic [7:0] fi; logic to;} st_t;
    logic [31:0] exp_aw[$], exp_ar[$];
    logic [63:0] exp_w[$];
    st_t exp_st[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: pops expectations whenever the selected DUT completes a handshake or finishes
    logic prev_done = 1'b0;
    st_t st;
    always @(negedge ACLK) begin
        if (m_awvalid && s_awready) begin
            if (exp_aw.size() == 0) begin
                n_total++; $display("FAIL aw_extra: unexpected write address %0h", m_awaddr);
            end else begin
                chk("awaddr", m_awaddr, exp_aw.pop_front());
                chk("awprot", m_awprot, 0);
            end
        end
        if (m_wvalid && s_wready) begin
            if (exp_w.size() == 0) begin
                n_total++; $display("FAIL w_extra: unexpected write data %0h", m_wdata);
            end else begin
                chk("wdata", m_wdata, exp_w.pop_front());
                chk("wstrb", m_wstrb, sel ? 8'hFF : 8'h0F);
            end
        end
        if (m_arvalid && s_arready) begin
            if (exp_ar.size() == 0) begin
                n_total++; $display("FAIL ar_extra: unexpected read address %0h", m_araddr);
            end else begin
                chk("araddr", m_araddr, exp_ar.pop_front());
                chk("arprot", m_arprot, 0);
            end
        end
        if (m_done && !prev_done) begin
            if (exp_st.size() == 0) begin
                n_total++; $display("FAIL done_extra: unexpected completion");
            end else begin
                st = exp_st.pop_front();
                chk("pass", m_pass, st.p);
                chk("err_count", m_err, st.e);
                chk("first_err_idx", m_fi, st.fi);
                chk("timeout", m_to, st.to);
            end
        end
        prev_done <= m_done;
    end

    logic [31:0] lfsr_tab [8] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001,
                                  32'hB02C_0003, 32'hD836_0002, 32'h6C1B_0001, 32'hB62D_8003};

    task automatic push_mode0(input bit with_reads, input st_t s);
        for (int i = 0; i < 4; i++) begin
            exp_aw.push_back(32'(i * 4));
            exp_w.push_back(64'(i + 1));
            if (with_reads) exp_ar.push_back(32'(i * 4));
        end
        exp_st.push_back(s);
    endtask

    task automatic do_run(output int n, output int ar_n);
        n = 0; ar_n = 0;
        @(negedge ACLK);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge ACLK);
            start0 = 1'b0; start1 = 1'b0;
            n++;
            if (m_arvalid) ar_n++;
            if (m_done) break;
        end
        if (!m_done) begin
            n_total++; $display("FAIL run_timeout: done not seen after %0d cycles", n);
        end
    endtask

    task automatic post_check();
        repeat (3) @(negedge ACLK);
        chk("queues_empty", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_st.size()), 0);
        chk("done_hold", m_done, 1);
        chk("busy_idle", m_busy, 0);
    endtask

    int n, ar_n;
    bit found;
    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
        aw_dly = 0; w_dly = 0; ar_block = 1'b0; corrupt = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_busy", d0_busy, 0);
        chk("rst_done", d0_done, 0);
        chk("rst_pass", d0_pass, 0);
        chk("rst_timeout", d0_to, 0);
        chk("rst_err", d0_err, 0);
        chk("rst_valids", {d0_awvalid, d0_wvalid, d0_bready, d0_arvalid, d0_rready}, 0);
        chk("rst_addr_data", {d0_awaddr, d0_wdata}, 0);
        chk("rst_d1_wdata", d1_wdata, 0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(negedge ACLK);

        // basic run, zero-latency slave: 2 cycles per write and per read
        push_mode0(1, '{p: 1'b1, e: 4'd0, fi: 8'd0, to: 1'b0});
        do_run(n, ar_n);
        chk("run_cycles", n, 17);
        post_check();

        // corrupted read of word 2
        corrupt = 1'b1;
        push_mode0(1, '{p: 1'b0, e: 4'd1, fi: 8'd2, to: 1'b0});
        do_run(n, ar_n);
        post_check();
        corrupt = 1'b0;

        // W ready 3 cycles after AW, then the reverse
        w_dly = 3;
        push_mode0(1, '{p: 1'b1, e: 4'd0, fi: 8'd0, to: 1'b0});
        do_run(n, ar_n);
        chk("run_cycles_wlate", n, 29);
        post_check();
        w_dly = 0; aw_dly = 3;
        push_mode0(1, '{p: 1'b1, e: 4'd0, fi: 8'd0, to: 1'b0});
        do_run(n, ar_n);
        chk("run_cycles_awlate", n, 29);
        post_check();
        aw_dly = 0;

        // read address never accepted
        ar_block = 1'b1;
        push_mode0(0, '{p: 1'b0, e: 4'd0, fi: 8'd0, to: 1'b1});
        do_run(n, ar_n);
        chk("arvalid_cycles", ar_n, 17);
        chk("run_cycles_timeout", n, 26);
        post_check();
        ar_block = 1'b0;

        // reset during the third write with AWVALID held high
        aw_dly = 5;
        push_mode0(1, '{p: 1'b1, e: 4'd0, fi: 8'd0, to: 1'b0});
        @(negedge ACLK);
        start0 = 1'b1;
        @(negedge ACLK);
        start0 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (m_awvalid && m_awaddr == 32'h8) begin found = 1'b1; break; end
            @(negedge ACLK);
        end
        chk("third_write_seen", found, 1);
        rst0_n = 1'b0;
        #1;
        chk("abort_valids", {d0_awvalid, d0_wvalid}, 0);
        chk("abort_busy", d0_busy, 0);
        chk("abort_done", d0_done, 0);
        chk("abort_aw_remaining", exp_aw.size(), 2);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_st.delete();
        repeat (2) @(negedge ACLK);
        rst0_n = 1'b1;
        aw_dly = 0;
        push_mode0(1, '{p: 1'b1, e: 4'd0, fi: 8'd0, to: 1'b0});
        do_run(n, ar_n);
        chk("run_cycles_after_reset", n, 17);
        post_check();

        // 64-bit LFSR instance with SEED=0
        @(negedge ACLK);
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_aw.push_back(32'(i * 8));
            exp_w.push_back({lfsr_tab[i], lfsr_tab[i]});
            exp_ar.push_back(32'(i * 8));
        end
        exp_st.push_back('{p: 1'b1, e: 4'd0, fi: 8'd0, to: 1'b0});
        do_run(n, ar_n);
        chk("run_cycles_lfsr", n, 33);
        post_check();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
